// File: rtl/alu_mc.sv
// alu_mc: handshaked ALU with single-cycle ops and bit-serial MUL (and optional DIVU/REMU).
// Define ALU_MC_DIV_EN to build the restoring divider; otherwise 0100/0101 behave as undefined codes.
module alu_mc #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [DATA_WIDTH-1:0]    SrcA,
   input  logic [DATA_WIDTH-1:0]    SrcB,
   input  logic [OPCODE_LENGTH-1:0] Operation,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [DATA_WIDTH-1:0]    ALUResult,
   output logic                     busy
);
   localparam int SHW = $clog2(DATA_WIDTH);
   localparam logic [SHW-1:0] LAST_ITER = SHW'(DATA_WIDTH - 1);

   localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
   localparam logic [OPCODE_LENGTH-1:0] OP_XOR = OPCODE_LENGTH'(4'b0001);
   localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0010);
   localparam logic [OPCODE_LENGTH-1:0] OP_MUL = OPCODE_LENGTH'(4'b0011);
   localparam logic [OPCODE_LENGTH-1:0] OP_SLL = OPCODE_LENGTH'(4'b0110);
   localparam logic [OPCODE_LENGTH-1:0] OP_SRA = OPCODE_LENGTH'(4'b0111);
   localparam logic [OPCODE_LENGTH-1:0] OP_EQ  = OPCODE_LENGTH'(4'b1000);
   localparam logic [OPCODE_LENGTH-1:0] OP_SLT = OPCODE_LENGTH'(4'b1100);
`ifdef ALU_MC_DIV_EN
   localparam logic [OPCODE_LENGTH-1:0] OP_DIVU = OPCODE_LENGTH'(4'b0100);
   localparam logic [OPCODE_LENGTH-1:0] OP_REMU = OPCODE_LENGTH'(4'b0101);
`endif

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t                  state_reg, state_next;
   logic [SHW-1:0]          cnt_reg, cnt_next;
   logic [DATA_WIDTH-1:0]   result_reg, result_next;
   logic [DATA_WIDTH-1:0]   mcand_reg, mcand_next;
   logic [DATA_WIDTH-1:0]   mplier_reg, mplier_next;
   logic [DATA_WIDTH-1:0]   prod_reg, prod_next;
`ifdef ALU_MC_DIV_EN
   logic [DATA_WIDTH-1:0]   quo_reg, quo_next;
   logic [DATA_WIDTH-1:0]   rem_reg, rem_next;
   logic [DATA_WIDTH-1:0]   dvsr_reg, dvsr_next;
   logic                    div_sel_reg, div_sel_next;
   logic                    rem_sel_reg, rem_sel_next;
   logic [DATA_WIDTH:0]     rem_shift;
`endif

   logic [DATA_WIDTH-1:0]   and_bits, xor_bits, single_res;
   logic [SHW-1:0]          shamt;
   logic                    start_iter;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_bitwise
         assign and_bits[gi] = SrcA[gi] & SrcB[gi];
         assign xor_bits[gi] = SrcA[gi] ^ SrcB[gi];
      end
   endgenerate

   assign shamt = SrcB[SHW-1:0];

   // Result of every op that completes in the acceptance cycle; unknown codes give 0.
   always_comb begin
      single_res = '0;
      case (Operation)
         OP_AND:  single_res = and_bits;
         OP_XOR:  single_res = xor_bits;
         OP_ADD:  single_res = SrcA + SrcB;
         OP_SLL:  single_res = SrcA << shamt;
         OP_SRA:  single_res = $signed(SrcA) >>> shamt;
         OP_EQ:   single_res = DATA_WIDTH'(SrcA == SrcB);
         OP_SLT:  single_res = DATA_WIDTH'($signed(SrcA) < $signed(SrcB));
         default: single_res = '0;
      endcase
   end

   always_comb begin
      start_iter = (Operation == OP_MUL);
`ifdef ALU_MC_DIV_EN
      if (Operation == OP_DIVU || Operation == OP_REMU) begin
         start_iter = 1'b1;
      end
`endif
   end

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      result_next  = result_reg;
      mcand_next   = mcand_reg;
      mplier_next  = mplier_reg;
      prod_next    = prod_reg;
`ifdef ALU_MC_DIV_EN
      quo_next     = quo_reg;
      rem_next     = rem_reg;
      dvsr_next    = dvsr_reg;
      div_sel_next = div_sel_reg;
      rem_sel_next = rem_sel_reg;
      rem_shift    = '0;
`endif
      case (state_reg)
         IDLE: begin
            if (in_valid) begin
               if (start_iter) begin
                  state_next  = BUSY;
                  cnt_next    = '0;
                  mcand_next  = SrcA;
                  mplier_next = SrcB;
                  prod_next   = '0;
`ifdef ALU_MC_DIV_EN
                  quo_next     = SrcA;
                  rem_next     = '0;
                  dvsr_next    = SrcB;
                  div_sel_next = (Operation != OP_MUL);
                  rem_sel_next = (Operation == OP_REMU);
`endif
               end else begin
                  state_next  = DONE;
                  result_next = single_res;
               end
            end
         end
         BUSY: begin
            cnt_next    = cnt_reg + SHW'(1);
            // Shift-add: multiplier LSB gates the multiplicand, which walks left each step.
            prod_next   = prod_reg + (mplier_reg[0] ? mcand_reg : '0);
            mcand_next  = mcand_reg << 1;
            mplier_next = mplier_reg >> 1;
`ifdef ALU_MC_DIV_EN
            // Restoring step; a zero divisor always "fits", giving all-ones quotient and rem = SrcA.
            rem_shift = {rem_reg, quo_reg[DATA_WIDTH-1]};
            if (rem_shift >= {1'b0, dvsr_reg}) begin
               rem_next = rem_shift[DATA_WIDTH-1:0] - dvsr_reg;
               quo_next = {quo_reg[DATA_WIDTH-2:0], 1'b1};
            end else begin
               rem_next = rem_shift[DATA_WIDTH-1:0];
               quo_next = {quo_reg[DATA_WIDTH-2:0], 1'b0};
            end
`endif
            if (cnt_reg == LAST_ITER) begin
               state_next  = DONE;
`ifdef ALU_MC_DIV_EN
               if (!div_sel_reg) begin
                  result_next = prod_next;
               end else if (rem_sel_reg) begin
                  result_next = rem_next;
               end else begin
                  result_next = quo_next;
               end
`else
               result_next = prod_next;
`endif
            end
         end
         DONE: begin
            if (out_ready) begin
               state_next  = IDLE;
               result_next = '0;
            end
         end
         default: begin
            state_next  = IDLE;
            result_next = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         result_reg  <= '0;
         mcand_reg   <= '0;
         mplier_reg  <= '0;
         prod_reg    <= '0;
`ifdef ALU_MC_DIV_EN
         quo_reg     <= '0;
         rem_reg     <= '0;
         dvsr_reg    <= '0;
         div_sel_reg <= 1'b0;
         rem_sel_reg <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         result_reg  <= result_next;
         mcand_reg   <= mcand_next;
         mplier_reg  <= mplier_next;
         prod_reg    <= prod_next;
`ifdef ALU_MC_DIV_EN
         quo_reg     <= quo_next;
         rem_reg     <= rem_next;
         dvsr_reg    <= dvsr_next;
         div_sel_reg <= div_sel_next;
         rem_sel_reg <= rem_sel_next;
`endif
      end
   end

   assign in_ready  = (state_reg == IDLE);
   assign out_valid = (state_reg == DONE);
   assign busy      = (state_reg == BUSY);
   assign ALUResult = result_reg;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed cases plus random ops against an arithmetic model.
module tb_alu_mc;
   localparam int W = 32;

   logic          clk = 1'b0;
   logic          rst_n, in_valid, in_ready, out_valid, out_ready, busy;
   logic [W-1:0]  SrcA, SrcB, ALUResult;
   logic [3:0]    Operation;
   int            total = 0;
   int            bad = 0;

`ifdef ALU_MC_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   always #5 clk = ~clk;

   alu_mc #(.DATA_WIDTH(W), .OPCODE_LENGTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation), .out_valid(out_valid),
      .out_ready(out_ready), .ALUResult(ALUResult), .busy(busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      logic [W-1:0] ones = '1;
      logic [W-1:0] msb  = 32'h8000_0000;
      logic [63:0]  p;
      int unsigned  sh = b % W;
      case (op)
         4'b0000: return a & b;
         4'b0001: return a ^ b;
         4'b0010: return a + b;
         4'b0110: return a << sh;
         4'b0111: return (a >> sh) | ((a & msb) != 0 ? ~(ones >> sh) : '0);
         4'b1000: return (a == b) ? W'(1) : W'(0);
         4'b1100: return ((a ^ msb) < (b ^ msb)) ? W'(1) : W'(0);
         4'b0011: begin p = 64'(a) * 64'(b); return p[W-1:0]; end
         4'b0100: return !DIV_EN ? '0 : (b == 0) ? ones : a / b;
         4'b0101: return !DIV_EN ? '0 : (b == 0) ? a : a % b;
         default: return '0;
      endcase
   endfunction

   function automatic bit is_iter(input logic [3:0] op);
      return (op == 4'b0011) || (DIV_EN && (op == 4'b0100 || op == 4'b0101));
   endfunction

   task automatic scramble();
      in_valid  = 1'($urandom_range(0, 1));
      Operation = 4'($urandom);
      SrcA      = $urandom;
      SrcB      = $urandom;
   endtask

   // One transaction: accept, measure latency/busy, hold for 'stall' cycles, then hand off.
   task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input int stall, input string tag);
      logic [W-1:0] exp_res = model(op, a, b);
      int           exp_lat = is_iter(op) ? W + 1 : 1;
      int           lat = 1;
      int           busy_cnt = 0;
      int           early_res = 0;
      int           stall_bad = 0;
      check({tag, ":in_ready_pre"}, W'(in_ready), W'(1));
      in_valid = 1'b1; Operation = op; SrcA = a; SrcB = b; out_ready = 1'b0;
      tick();
      scramble();
      while (!out_valid && lat < 200) begin
         if (busy) busy_cnt++;
         if (ALUResult !== '0) early_res++;
         tick();
         lat++;
         scramble();
      end
      check({tag, ":latency"}, W'(lat), W'(exp_lat));
      check({tag, ":busy_cycles"}, W'(busy_cnt), is_iter(op) ? W'(W) : W'(0));
      check({tag, ":result_zero_before_done"}, W'(early_res), W'(0));
      check({tag, ":result"}, ALUResult, exp_res);
      for (int i = 0; i < stall; i++) begin
         tick();
         scramble();
         if (ALUResult !== exp_res || in_ready !== 1'b0 || out_valid !== 1'b1) stall_bad++;
      end
      check({tag, ":stall_hold"}, W'(stall_bad), W'(0));
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b0;
      check({tag, ":in_ready_post"}, W'(in_ready), W'(1));
      check({tag, ":out_valid_post"}, W'(out_valid), W'(0));
      check({tag, ":result_idle"}, ALUResult, '0);
      $display("txn %s op=%b a=%h b=%h exp=%h lat=%0d", tag, op, a, b, exp_res, lat);
   endtask

   initial begin
      int           quiet;
      logic [3:0]   rop;
      logic [W-1:0] ra, rb;

      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      SrcA = '0; SrcB = '0; Operation = '0;
      tick();
      tick();
      check("reset:in_ready", W'(in_ready), W'(1));
      check("reset:out_valid", W'(out_valid), W'(0));
      check("reset:busy", W'(busy), W'(0));
      check("reset:result", ALUResult, '0);
      rst_n = 1'b1;
      tick();

      run_op(4'b0010, 32'hFFFF_FFFF, 32'h0000_0002, 0, "add_wrap");
      run_op(4'b1100, 32'hFFFF_FFFE, 32'h0000_0001, 0, "slt_neg");
      run_op(4'b0111, 32'h8000_0000, 32'h0000_0024, 0, "sra_fill");
      run_op(4'b0011, 32'h0001_2345, 32'h0001_0000, 0, "mul");
      run_op(4'b0100, 32'd100, 32'd7, 0, "divu");
      run_op(4'b0101, 32'd100, 32'd7, 0, "remu");
      run_op(4'b0100, 32'd5, 32'd0, 0, "divu_zero");
      run_op(4'b0101, 32'd5, 32'd0, 0, "remu_zero");
      run_op(4'b0001, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 5, "xor_backpressure");
      run_op(4'b1000, 32'h1234_5678, 32'h1234_5678, 1, "equal");
      run_op(4'b0110, 32'h0000_0003, 32'hFFFF_FFE1, 0, "sll");
      run_op(4'b1111, 32'hDEAD_BEEF, 32'h1, 0, "undefined");

      // Reset part-way through a multiply discards it.
      in_valid = 1'b1; Operation = 4'b0011; SrcA = 32'h0000_0FFF; SrcB = 32'h0000_0FFF;
      tick();
      in_valid = 1'b0;
      repeat (8) tick();
      rst_n = 1'b0;
      tick();
      check("mul_reset:in_ready", W'(in_ready), W'(1));
      check("mul_reset:busy", W'(busy), W'(0));
      check("mul_reset:out_valid", W'(out_valid), W'(0));
      check("mul_reset:result", ALUResult, '0);
      rst_n = 1'b1;
      quiet = 0;
      repeat (40) begin
         tick();
         if (out_valid !== 1'b0 || busy !== 1'b0) quiet++;
      end
      check("mul_reset:no_late_result", W'(quiet), W'(0));
      $display("txn mul_reset aborted");

      // Reset wins over a simultaneous result handshake and a new request.
      in_valid = 1'b1; Operation = 4'b0001; SrcA = 32'h5; SrcB = 32'h3;
      tick();
      check("prio:done", W'(out_valid), W'(1));
      Operation = 4'b0011; out_ready = 1'b1; rst_n = 1'b0;
      tick();
      in_valid = 1'b0; out_ready = 1'b0; rst_n = 1'b1;
      check("prio:in_ready", W'(in_ready), W'(1));
      check("prio:busy", W'(busy), W'(0));
      check("prio:out_valid", W'(out_valid), W'(0));
      tick();
      check("prio:still_idle", W'(in_ready), W'(1));
      $display("txn reset_priority");

      for (int n = 0; n < 40; n++) begin
         rop = 4'($urandom_range(0, 15));
         ra  = $urandom;
         case ($urandom_range(0, 3))
            0:       rb = W'($urandom_range(0, 20));
            1:       rb = '0;
            default: rb = $urandom;
         endcase
         run_op(rop, ra, rb, int'($urandom_range(0, 2)), $sformatf("rand%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/alu_mc.md
ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; power of two, 8..64.
REQ-002 Parameter OPCODE_LENGTH, default 4, width of Operation.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 in_valid  input  1  request present on SrcA/SrcB/Operation.
REQ-006 in_ready  output  1  block can accept a request.
REQ-007 SrcA  input  DATA_WIDTH  operand A.
REQ-008 SrcB  input  DATA_WIDTH  operand B.
REQ-009 Operation  input  OPCODE_LENGTH  operation select.
REQ-010 out_valid  output  1  ALUResult holds a completed result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 ALUResult  output  DATA_WIDTH  registered result.
REQ-013 busy  output  1  high in BUSY state (iterative op in progress).

Function
REQ-014 Opcodes SHALL be: 0000 AND, 0001 XOR, 0010 ADD, 0110 SLL, 0111 SRA, 1000 EQUAL (1/0), 1100 SLT (signed, 1/0), 0011 MUL (low DATA_WIDTH bits), 0100 DIVU, 0101 REMU; any other code yields result 0.
REQ-015 Shift amount SHALL be SrcB[log2(DATA_WIDTH)-1:0]; SRA sign-fills from SrcA MSB; ADD wraps modulo 2^DATA_WIDTH.
REQ-016 States SHALL be IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE; busy=1 only in BUSY.
REQ-017 Acceptance SHALL occur on a cycle with in_valid=1 and in_ready=1; operands and opcode are captured then and later input changes have no effect.
REQ-018 Single-cycle ops and undefined codes: IDLE->DONE; out_valid rises the cycle after acceptance.
REQ-019 MUL, DIVU, REMU: IDLE->BUSY; shift-add multiply / restoring divide, one bit per cycle, internal counter DATA_WIDTH iterations; BUSY->DONE; out_valid rises exactly DATA_WIDTH+1 cycles after acceptance.
REQ-020 DIVU by zero SHALL return all ones; REMU by zero SHALL return SrcA; counter still runs full length (fixed latency).
REQ-021 DONE SHALL hold ALUResult and out_valid stable until out_ready=1; on that cycle state returns to IDLE.
REQ-022 in_ready SHALL not depend combinationally on out_ready; a new request is accepted no earlier than the cycle after result handshake.
REQ-023 in_valid asserted while not in IDLE SHALL be ignored (no capture, no state change).
REQ-024 ALUResult SHALL be 0 in IDLE and BUSY.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE, counter 0, ALUResult 0, out_valid 0, busy 0, in_ready 1 on the next cycle.
REQ-026 Reset in BUSY or DONE SHALL abort the operation and discard its result; no out_valid pulse follows.
REQ-027 Reset SHALL have priority over any simultaneous handshake.

Configuration
REQ-028 Macro ALU_MC_DIV_EN defined: DIVU/REMU implemented per REQ-019/020.
REQ-029 ALU_MC_DIV_EN undefined: divider logic absent; 0100/0101 treated as undefined codes (result 0, single-cycle); MUL unaffected.

Verification
REQ-030 ADD SrcA=0xFFFFFFFF, SrcB=0x00000002, out_ready=1 -> out_valid one cycle after acceptance, ALUResult=0x00000001, then in_ready=1.
REQ-031 SLT SrcA=0xFFFFFFFE, SrcB=0x00000001 -> 1; SRA SrcA=0x80000000, SrcB=0x00000024 -> 0xF8000000 (shift 4).
REQ-032 MUL 0x00012345 x 0x00010000 -> out_valid 33 cycles after acceptance, ALUResult=0x23450000, busy high 32 cycles.
REQ-033 With ALU_MC_DIV_EN: DIVU 100/7 -> 14, REMU 100/7 -> 2, DIVU 5/0 -> 0xFFFFFFFF, REMU 5/0 -> 5; without: DIVU 100/7 -> 0 after 1 cycle.
REQ-034 Backpressure: out_ready=0 for 5 cycles after XOR 0xF0F0F0F0^0x0F0F0F0F -> ALUResult=0xFFFFFFFF held stable, in_ready=0, in_valid pulses ignored; released -> IDLE next cycle.
REQ-035 rst_n=0 at cycle 10 of a MUL -> next cycle IDLE, out_valid=0, ALUResult=0; no result emitted later.
